ripple_carry_adder_detailed_routing: RTL and testbench

//   Parameterised WIDTH-bit binary adder: Sum/Cout = A + B + Cin.

---
 rtl/ripple_carry_adder_detailed_routing_pkg.sv | 16 +
 rtl/ripple_carry_adder_detailed_routing_if.sv | 15 +
 rtl/ripple_carry_adder_detailed_routing_full_adder.sv | 15 +
 rtl/ripple_carry_adder_detailed_routing.sv | 36 +++
 tb/tb_ripple_carry_adder_detailed_routing.sv | 122 ++++++++++++
 5 files changed

// File: rtl/ripple_carry_adder_detailed_routing_pkg.sv
// Shared constants and 1-bit full-adder cell equations for the registered
// ripple-carry adder.
package ripple_carry_adder_detailed_routing_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   function automatic logic fa_sum(input logic a, input logic b, input logic ci);
      return a ^ b ^ ci;
   endfunction

   // Generate when both operands are set, propagate an incoming carry otherwise.
   function automatic logic fa_carry(input logic a, input logic b, input logic ci);
      return (a & b) | (ci & (a ^ b));
   endfunction

endpackage

// File: rtl/ripple_carry_adder_detailed_routing_if.sv
// Operand/result bundle for the registered ripple-carry adder.
interface ripple_carry_adder_detailed_routing_if
   import ripple_carry_adder_detailed_routing_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (output A, output B, output Cin, input Sum, input Cout);
   modport slave  (input A, input B, input Cin, output Sum, output Cout);
endinterface

// File: rtl/ripple_carry_adder_detailed_routing_full_adder.sv
// Single full-adder cell; one instance per bit of the carry chain.
module full_adder
   import ripple_carry_adder_detailed_routing_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   always_comb begin
      s  = fa_sum(a, b, ci);
      co = fa_carry(a, b, ci);
   end
endmodule

// File: rtl/ripple_carry_adder_detailed_routing.sv
// WIDTH-bit adder built as an explicit chain of full_adder cells, with
// {Cout,Sum} = A + B + Cin captured in an output register.
module ripple_carry_adder_detailed_routing
   import ripple_carry_adder_detailed_routing_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
)(
   input  logic                                    clk,
   input  logic                                    rst,
   ripple_carry_adder_detailed_routing_if.slave    bus
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = bus.Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a  (bus.A[i]),
         .b  (bus.B[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Sum  <= '0;
         bus.Cout <= 1'b0;
      end else begin
         bus.Sum  <= s;
         bus.Cout <= c[WIDTH];
      end
   end
endmodule

// File: tb/tb_ripple_carry_adder_detailed_routing.sv
// Directed and random bench for the registered ripple-carry adder (WIDTH=8).
module tb_ripple_carry_adder_detailed_routing;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ripple_carry_adder_detailed_routing_if #(.WIDTH(W)) bus ();

   ripple_carry_adder_detailed_routing #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got {Cout,Sum}=%h expected %h", tag, got, exp);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W:0]   exp;
      string        tag;
   } vec_t;

   vec_t dir[$] = '{
      '{8'h00, 8'h00, 1'b0, 9'h000, "zero"},
      '{8'h0F, 8'h0F, 1'b0, 9'h01E, "0f+0f"},
      '{8'h0F, 8'h0F, 1'b1, 9'h01F, "0f+0f+1"},
      '{8'h07, 8'h01, 1'b0, 9'h008, "07+01"},
      '{8'h07, 8'h00, 1'b1, 9'h008, "07+cin"},
      '{8'h08, 8'h08, 1'b1, 9'h011, "08+08+1"},
      '{8'hFF, 8'h01, 1'b0, 9'h100, "ff+01"},
      '{8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff+ff+1"},
      '{8'hFF, 8'h00, 1'b1, 9'h100, "ff+00+1"},
      '{8'h0A, 8'h05, 1'b0, 9'h00F, "0a+05"},
      '{8'h0D, 8'h0B, 1'b0, 9'h018, "0d+0b"},
      '{8'h0E, 8'h01, 1'b1, 9'h010, "0e+01+1"}
   };

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      @(negedge clk);
      bus.A   = a;
      bus.B   = b;
      bus.Cin = ci;
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   endfunction

   logic [W:0]   prev;
   logic [W:0]   exp_v;
   logic [W-1:0] ra, rb;
   logic         rc;

   initial begin
      bus.A = 8'hFF; bus.B = 8'hFF; bus.Cin = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("reset", {bus.Cout, bus.Sum}, 9'h000);

      // First edge after release loads the inputs present at that edge.
      drive(8'h0F, 8'h0F, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1 check("release", {bus.Cout, bus.Sum}, 9'h01F);

      foreach (dir[i]) begin
         drive(dir[i].a, dir[i].b, dir[i].ci);
         @(posedge clk); #1 check(dir[i].tag, {bus.Cout, bus.Sum}, dir[i].exp);
      end

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         drive(ra, rb, rc);
         @(posedge clk); #1 check("random", {bus.Cout, bus.Sum}, ref_add(ra, rb, rc));
      end

      // Streaming: new operands every cycle, outputs must hold until the next edge.
      prev = {bus.Cout, bus.Sum};
      for (int i = 0; i < 8; i++) begin
         ra = W'(8'h21 * (i + 1)); rb = W'(8'h3B * (i + 3)); rc = 1'(i);
         exp_v = ref_add(ra, rb, rc);
         drive(ra, rb, rc);
         #1 check("hold", {bus.Cout, bus.Sum}, prev);
         if (i == 4) rst = 1'b1;
         @(posedge clk); #1;
         if (i == 4) begin
            check("midrst", {bus.Cout, bus.Sum}, 9'h000);
            prev = '0;
            @(negedge clk) rst = 1'b0;
            @(posedge clk); #1 check("resume", {bus.Cout, bus.Sum}, exp_v);
            prev = exp_v;
         end else begin
            check("stream", {bus.Cout, bus.Sum}, exp_v);
            prev = exp_v;
         end
      end

      // Reset wins over all-ones operands mid-stream.
      drive(8'hFF, 8'hFF, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1 check("rst_prio", {bus.Cout, bus.Sum}, 9'h000);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1 check("post_rst", {bus.Cout, bus.Sum}, 9'h1FF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
